alu_result_uart_tx: RTL and testbench
=====================================

# alu_result_uart_tx

Serial transmit path for the ALU result: accepts one NB_DATA-bit word from the ALU output stage on a start strobe and shifts it out as an asynchronous 8N1-style frame (start bit, data LSB first, stop). It is the return direction of the operand-loading front end. Operands and opcode come in, and this block sends the result back to the host over a single TX line. It contains its own baud-tick divider, which is restarted on every accepted frame so that frame timing is deterministic.

## Interface
- NB_DATA, 8, data bits per frame
- SB_TICK, 16, stop-bit length in oversampling ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- OVS, 16, oversampling ticks per start/data bit
- DVSR, 163, clock cycles per oversampling tick (50 MHz / (19200·16))
- i_clk  input  1  system clock, single clock domain
- i_reset  input  1  synchronous, active-high reset
- i_tx_start  input  1  request to transmit i_data; sampled only in IDLE
- i_data  input  NB_DATA  result word, captured on the accepting edge
- o_tx  output  1  serial line, idle high
- o_busy  output  1  high while a frame is in progress (START, DATA, STOP)
- o_tx_done_tick  output  1  one-cycle pulse after the stop bit completes

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - o_tx = 1.
  - On i_tx_start = 1, latch i_data into the shift register, clear the tick counter, clear the divider, and go to START.
- START:
  - o_tx = 0.
  - Count ticks. At tick OVS-1, clear the tick counter and bit counter, then go to DATA.
- DATA:
  - o_tx = shift_reg[0].
  - At tick OVS-1, shift right and increment the bit counter.
  - When the bit counter reaches NB_DATA-1 at that tick, go to STOP.
- STOP:
  - o_tx = 1.
  - At tick SB_TICK-1, go to IDLE and assert o_tx_done_tick.
- i_tx_start outside IDLE is ignored. No queueing, and i_data is not re-sampled.
- i_data changes after acceptance have no effect on the frame.
- Reset values: state IDLE, o_tx = 1, o_busy = 0, o_tx_done_tick = 0, all counters and the shift register 0.
- Reset mid-frame: the frame is abandoned. o_tx = 1 and o_busy = 0 from the edge where i_reset is sampled high. No done tick is issued.
- i_reset and i_tx_start high on the same edge: reset wins and the request is dropped.

## Timing
- o_tx, o_busy and o_tx_done_tick are registered outputs, with no combinational input-to-output path.
- Let edge A be the edge that accepts i_tx_start.
- Divider: a counter 0..DVSR-1 that is cleared at edge A. The tick fires when the count equals DVSR-1, so ticks land at A+DVSR, A+2·DVSR, and so on.
- Start bit: o_tx = 0 for exactly OVS·DVSR cycles, beginning the cycle after A.
- Data bit k occupies cycles A + (1+k)·OVS·DVSR + 1 through A + (2+k)·OVS·DVSR.
- Stop bit: SB_TICK·DVSR cycles.
- Frame length is F = ((1+NB_DATA)·OVS + SB_TICK)·DVSR cycles. The return to IDLE happens at edge A+F.
- o_tx_done_tick is high for exactly the one cycle after edge A+F. o_busy is low in that same cycle.
- Back-to-back frames: an i_tx_start held high is accepted at edge A+F+1, which gives an idle gap of one cycle (o_tx = 1).
- o_busy goes high the cycle after A and stays high through edge A+F.

## Structure
- Shared Verilog include `alu_uart_defs.vh` holds:
  - state encodings (2-bit localparams: IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11);
  - default OVS, SB_TICK and DVSR, also reused by the future RX block.
- One sub-module, `baud_tick_gen`:
  - parameter DVSR;
  - ports i_clk, i_reset, i_clear (synchronous, same priority as reset) and o_tick (one-cycle pulse);
  - counter width $clog2(DVSR).
- Top level holds the FSM, the tick counter ($clog2(max(OVS,SB_TICK)) bits), the bit counter ($clog2(NB_DATA) bits) and the NB_DATA shift register.

## Test plan
All scenarios use DVSR=4, OVS=16, SB_TICK=16, NB_DATA=8, which gives F = 640.
- Reset: hold i_reset for 3 cycles, then release. o_tx = 1, o_busy = 0 and o_tx_done_tick = 0 every cycle before any start.
- Single frame, i_data = 8'hA5, start at edge A:
  - o_tx, sampled mid-bit every 64 cycles, reads 0, 1,0,1,0,0,1,0,1, 1 (start, LSB-first data, stop);
  - o_tx_done_tick is high only in cycle A+641;
  - o_busy is high in cycles A+1 through A+640.
- Back-to-back frames 8'h00 then 8'hFF with i_tx_start held high:
  - the second acceptance occurs at A+641;
  - o_tx is 1 for exactly one cycle between the two frames;
  - the second frame's data bits are all 1.
- Start while busy: pulse i_tx_start with i_data = 8'h3C at A+100 during an 8'h81 frame. The 8'h81 frame is transmitted unchanged, and exactly one done tick occurs.
- Reset mid-frame: assert i_reset at A+300.
  - o_tx = 1 and o_busy = 0 from A+301.
  - No done tick occurs.
  - A new start of 8'h5A after reset produces a correct full frame.
- Reset and start on the same edge: no frame starts and o_busy stays 0.

Source files
------------

// File: rtl/alu_result_uart_tx_pkg.sv
// rtl/alu_result_uart_tx_pkg.sv - shared state encoding, default UART timing and width helpers
package alu_result_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_e;

  // 50 MHz system clock, 19200 baud, 16x oversampling; also the defaults for the RX side
  localparam int DEF_NB_DATA = 8;
  localparam int DEF_OVS     = 16;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_DVSR    = 163;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_result_uart_tx_if.sv
// rtl/alu_result_uart_tx_if.sv - request/serial-status bundle between the ALU output stage and the TX block
interface alu_result_uart_tx_if #(
  parameter int NB_DATA = 8
);
  logic               i_tx_start;
  logic [NB_DATA-1:0] i_data;
  logic               o_tx;
  logic               o_busy;
  logic               o_tx_done_tick;

  modport master (
    output i_tx_start, i_data,
    input  o_tx, o_busy, o_tx_done_tick
  );

  modport slave (
    input  i_tx_start, i_data,
    output o_tx, o_busy, o_tx_done_tick
  );
endinterface

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - oversampling tick divider, restartable so frame timing is deterministic
module baud_tick_gen
  import alu_result_uart_tx_pkg::*;
#(
  parameter int DVSR = DEF_DVSR
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);
  localparam int CW = clog2_min1(DVSR);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      cnt <= '0;
    end else if (cnt == CW'(DVSR - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign o_tick = (cnt == CW'(DVSR - 1));
endmodule

// File: rtl/alu_result_uart_tx.sv
// rtl/alu_result_uart_tx.sv - 8N1-style serial transmitter returning the ALU result word to the host
module alu_result_uart_tx
  import alu_result_uart_tx_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int OVS     = DEF_OVS,
  parameter int DVSR    = DEF_DVSR
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  alu_result_uart_tx_if.slave  bus
);
  localparam int TW = clog2_min1(max_int(OVS, SB_TICK));
  localparam int BW = clog2_min1(NB_DATA);

  state_e             state;
  logic [TW-1:0]      tick_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [NB_DATA-1:0] shift_reg;
  logic [NB_DATA-1:0] shifted;
  logic               tx_q;
  logic               busy_q;
  logic               done_q;
  logic               tick;
  logic               accept;

  assign accept  = (state == IDLE) && bus.i_tx_start;
  assign shifted = shift_reg >> 1;

  baud_tick_gen #(.DVSR(DVSR)) u_baud (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (accept),
    .o_tick  (tick)
  );

  // Outputs are computed one state ahead so they change on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.i_tx_start) begin
            shift_reg <= bus.i_data;
            tick_cnt  <= '0;
            state     <= START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: if (tick) begin
          if (tick_cnt == TW'(OVS - 1)) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx_q     <= shift_reg[0];
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        DATA: if (tick) begin
          if (tick_cnt == TW'(OVS - 1)) begin
            tick_cnt  <= '0;
            shift_reg <= shifted;
            bit_cnt   <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(NB_DATA - 1)) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              tx_q <= shifted[0];
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        STOP: if (tick) begin
          if (tick_cnt == TW'(SB_TICK - 1)) begin
            tick_cnt <= '0;
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_tx           = tx_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_tx_done_tick = done_q;
endmodule

// File: tb/tb_alu_result_uart_tx.sv
// tb/tb_alu_result_uart_tx.sv - self-checking bench for alu_result_uart_tx against a frame-level model
module tb_alu_result_uart_tx;
  localparam int NB   = 8;
  localparam int OVS  = 16;
  localparam int SB   = 16;
  localparam int DVSR = 4;
  localparam int BITC = OVS * DVSR;
  localparam int F    = ((1 + NB) * OVS + SB) * DVSR;
  localparam logic [2:0] IDLE_OUT = 3'b100;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [2:0] obs;

  always #5 clk = ~clk;

  alu_result_uart_tx_if #(.NB_DATA(NB)) bus ();

  alu_result_uart_tx #(.NB_DATA(NB), .SB_TICK(SB), .OVS(OVS), .DVSR(DVSR)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  assign obs = {bus.o_tx, bus.o_busy, bus.o_tx_done_tick};

  // {tx, busy, done} expected in cycle n after the accepting edge (n = 1 .. F+1)
  function automatic logic [2:0] model_out(input logic [7:0] d, input int n);
    logic tx;
    if (n <= BITC)            tx = 1'b0;
    else if (n <= (1 + NB) * BITC) tx = d[(n - BITC - 1) / BITC];
    else                      tx = 1'b1;
    return {tx, (n >= 1 && n <= F), (n == F + 1)};
  endfunction

  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    bus.i_data     = d;
    bus.i_tx_start = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_tx_start = 1'b0;
    bus.i_data = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b0;
      n_cmp++;
      if (obs !== IDLE_OUT) begin
        n_bad++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, obs, IDLE_OUT);
      end
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] mid_exp = 10'b1101001010;
    logic [2:0] e;
    start_frame(8'hA5);
    for (int n = 1; n <= F + 1; n++) begin
      @(negedge clk);
      if (n == 1) bus.i_tx_start = 1'b0;
      e = model_out(8'hA5, n);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL single n=%0d got=%b exp=%b", n, obs, e);
      end
      if ((n % BITC) == 32) begin
        n_cmp++;
        if (obs[2] !== mid_exp[n / BITC]) begin
          n_bad++;
          $display("FAIL midbit idx=%0d got=%b exp=%b", n / BITC, obs[2], mid_exp[n / BITC]);
        end
      end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    logic [2:0] e;
    int gap;
    repeat (4) begin
      d   = 8'($urandom);
      gap = $urandom_range(0, 20);
      repeat (gap) begin
        @(negedge clk);
        n_cmp++;
        if (obs !== IDLE_OUT) begin
          n_bad++;
          $display("FAIL rand_idle got=%b exp=%b", obs, IDLE_OUT);
        end
      end
      start_frame(d);
      for (int n = 1; n <= F + 1; n++) begin
        @(negedge clk);
        if (n == 1) begin
          bus.i_tx_start = 1'b0;
          bus.i_data = ~d;
        end
        e = model_out(d, n);
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL rand d=%h n=%0d got=%b exp=%b", d, n, obs, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    start_frame(8'h00);
    for (int n = 1; n <= F + 1; n++) begin
      @(negedge clk);
      if (n == 1) bus.i_data = 8'hFF;
      e = model_out(8'h00, n);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL b2b_first n=%0d got=%b exp=%b", n, obs, e);
      end
    end
    for (int n = 1; n <= F + 1; n++) begin
      @(negedge clk);
      if (n == 1) bus.i_tx_start = 1'b0;
      e = model_out(8'hFF, n);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL b2b_second n=%0d got=%b exp=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [2:0] e;
    int dones = 0;
    start_frame(8'h81);
    for (int n = 1; n <= F + 1 + 100; n++) begin
      @(negedge clk);
      if (n == 1)   bus.i_tx_start = 1'b0;
      if (n == 100) begin
        bus.i_tx_start = 1'b1;
        bus.i_data = 8'h3C;
      end
      if (n == 101) bus.i_tx_start = 1'b0;
      e = (n <= F + 1) ? model_out(8'h81, n) : IDLE_OUT;
      if (obs[0]) dones++;
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL busy_start n=%0d got=%b exp=%b", n, obs, e);
      end
    end
    n_cmp++;
    if (dones !== 1) begin
      n_bad++;
      $display("FAIL busy_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'($urandom);
    logic [2:0] e;
    start_frame(d);
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) bus.i_tx_start = 1'b0;
      e = model_out(d, n);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL abort_pre n=%0d got=%b exp=%b", n, obs, e);
      end
    end
    rst = 1'b1;
    for (int n = 301; n <= 400; n++) begin
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (obs !== IDLE_OUT) begin
        n_bad++;
        $display("FAIL abort_post n=%0d got=%b exp=%b", n, obs, IDLE_OUT);
      end
    end
    start_frame(8'h5A);
    for (int n = 1; n <= F + 1; n++) begin
      @(negedge clk);
      if (n == 1) bus.i_tx_start = 1'b0;
      e = model_out(8'h5A, n);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL abort_restart n=%0d got=%b exp=%b", n, obs, e);
      end
    end
  endtask

  task automatic test_reset_and_start();
    @(negedge clk);
    rst = 1'b1;
    bus.i_tx_start = 1'b1;
    bus.i_data = 8'($urandom);
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.i_tx_start = 1'b0;
      n_cmp++;
      if (obs !== IDLE_OUT) begin
        n_bad++;
        $display("FAIL rst_start n=%0d got=%b exp=%b", n, obs, IDLE_OUT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_random_frames();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_frame();
    test_reset_and_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
